// File: rtl/display_pkg.sv
// display_pkg: grid geometry, default 640x480@60 timing, colours and cell indexing
package display_pkg;
    localparam int GRID_COLS = 40;
    localparam int GRID_ROWS = 30;
    localparam int FB_BITS = GRID_COLS * GRID_ROWS;
    localparam int VGA_H_VISIBLE = 640;
    localparam int VGA_H_FP = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP = 48;
    localparam int VGA_V_VISIBLE = 480;
    localparam int VGA_V_FP = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP = 33;
    localparam int VGA_CELL_SHIFT = 4;
    localparam logic [11:0] VGA_FG_COLOR = 12'hFFF;
    localparam logic [11:0] VGA_BG_COLOR = 12'h000;
    localparam logic [11:0] GRID_COLOR = 12'h222;

    function automatic logic [10:0] cell_index(input logic [4:0] row, input logic [5:0] col);
        return 11'(row) * 11'(GRID_COLS) + 11'(GRID_COLS - 1) - 11'(col);
    endfunction
endpackage

// File: rtl/vga_grid_scanout_if.sv
// vga_grid_scanout_if: framebuffer in, VGA pins and frame tick out
interface vga_grid_scanout_if;
    import display_pkg::*;
    logic [FB_BITS-1:0] framebuffer;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic vga_hs;
    logic vga_vs;
    logic frame_start;
    modport master (input framebuffer, output vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start);
    modport slave (output framebuffer, input vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster counters, raw active-low syncs, visible flag and frame tick
module vga_timing
    import display_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP = VGA_V_BP
) (
    input  logic       clock,
    input  logic       reset,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       hs_raw_o,
    output logic       vs_raw_o,
    output logic       visible_o,
    output logic       frame_tick_o,
    output logic       frame_start_o
);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_LAST = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_LAST = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_VIS = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS = 10'(V_VISIBLE);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic frame_start_q;

    // Next raster position: h wraps at end of line, v advances on that wrap
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
        v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
    end

    // Counters plus the strobe raised the cycle after the first blank-line pixel
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_start_q <= frame_tick_o;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;
    assign hs_raw_o = !(h_cnt_q >= HS_FIRST && h_cnt_q <= HS_LAST);
    assign vs_raw_o = !(v_cnt_q >= VS_FIRST && v_cnt_q <= VS_LAST);
    assign visible_o = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign frame_tick_o = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
    assign frame_start_o = frame_start_q;
endmodule

// File: rtl/vga_grid_scanout.sv
// vga_grid_scanout: tear-free 40x30 cell framebuffer scanout; GRIDLINES_EN adds grey cell borders
module vga_grid_scanout
    import display_pkg::*;
#(
    parameter int H_VISIBLE = VGA_H_VISIBLE,
    parameter int H_FP = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP = VGA_H_BP,
    parameter int V_VISIBLE = VGA_V_VISIBLE,
    parameter int V_FP = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP = VGA_V_BP,
    parameter int CELL_SHIFT = VGA_CELL_SHIFT,
    parameter logic [11:0] FG_COLOR = VGA_FG_COLOR,
    parameter logic [11:0] BG_COLOR = VGA_BG_COLOR
) (
    input logic clock,
    input logic reset,
    vga_grid_scanout_if.master bus
);
    logic [9:0] h_cnt, v_cnt;
    logic hs_raw, vs_raw, visible, frame_tick;
    logic [FB_BITS-1:0] snap_q, snap_d;
    logic [10:0] idx;
    logic vis_q, cell_q, hs1_q, vs1_q;
    logic [11:0] rgb_q, colour;
    logic hs_q, vs_q;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clock(clock),
        .reset(reset),
        .h_cnt_o(h_cnt),
        .v_cnt_o(v_cnt),
        .hs_raw_o(hs_raw),
        .vs_raw_o(vs_raw),
        .visible_o(visible),
        .frame_tick_o(frame_tick),
        .frame_start_o(bus.frame_start)
    );

    // Index is only formed for visible positions so it never leaves the framebuffer
    always_comb begin
        idx = visible ? cell_index(5'(v_cnt >> CELL_SHIFT), 6'(h_cnt >> CELL_SHIFT)) : '0;
        snap_d = frame_tick ? bus.framebuffer : snap_q;
    end

    // Snapshot reloads once per frame at the start of vertical blank
    always_ff @(posedge clock) begin
        if (reset) snap_q <= '0;
        else snap_q <= snap_d;
    end

`ifdef GRIDLINES_EN
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);
    logic grid_q;

    // Grid flag travels through S1 next to the cell bit
    always_ff @(posedge clock) begin
        if (reset) grid_q <= 1'b0;
        else grid_q <= ((h_cnt & CELL_MASK) == '0) || ((v_cnt & CELL_MASK) == '0);
    end

    // Set cells win over the grid; blanking is black
    always_comb colour = !vis_q ? '0 : cell_q ? FG_COLOR : grid_q ? GRID_COLOR : BG_COLOR;
`else
    // Set cells foreground, clear cells background, blanking black
    always_comb colour = !vis_q ? '0 : cell_q ? FG_COLOR : BG_COLOR;
`endif

    // S1 samples the raster position, S2 holds the pin values; syncs ride with colour
    always_ff @(posedge clock) begin
        if (reset) begin
            vis_q <= 1'b0;
            cell_q <= 1'b0;
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            rgb_q <= '0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
        end else begin
            vis_q <= visible;
            cell_q <= visible && snap_q[idx];
            hs1_q <= hs_raw;
            vs1_q <= vs_raw;
            rgb_q <= colour;
            hs_q <= hs1_q;
            vs_q <= vs1_q;
        end
    end

    assign bus.vga_r = rgb_q[11:8];
    assign bus.vga_g = rgb_q[7:4];
    assign bus.vga_b = rgb_q[3:0];
    assign bus.vga_hs = hs_q;
    assign bus.vga_vs = vs_q;
endmodule

// File: tb/tb_vga_grid_scanout.sv
// tb_vga_grid_scanout: reduced-geometry scanout checked against a cycle-number raster model
module tb_vga_grid_scanout;
    localparam int HV = 80, HF = 4, HS = 12, HB = 6, HT = HV + HF + HS + HB;
    localparam int VV = 60, VF = 2, VS = 2, VB = 4, VT = VV + VF + VS + VB;
    localparam int CS = 1;
    localparam int FT = HT * VT;

    logic clock = 1'b0;
    logic reset = 1'b1;
    vga_grid_scanout_if bus();

    vga_grid_scanout #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(CS), .FG_COLOR(12'hFFF), .BG_COLOR(12'h000)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    logic started = 1'b0;
    logic [1199:0] msnap = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    endtask

    // cyc = pixel position index of the counters since the last reset edge
    always @(posedge clock) begin
        if (reset) begin
            started <= 1'b1;
            cyc <= 0;
            msnap <= '0;
        end else begin
            cyc <= cyc + 1;
            if (cyc % FT == VV * HT) msnap <= bus.framebuffer;
        end
    end

    function automatic logic [14:0] model(input int c);
        int p, h, v;
        logic vis, on, grid, hs, vs, fs;
        logic [11:0] rgb;
        fs = (c >= 1) && ((c - 1) % FT == VV * HT);
        if (c < 2) return {12'h000, 1'b1, 1'b1, fs};
        p = (c - 2) % FT;
        h = p % HT;
        v = p / HT;
        vis = (h < HV) && (v < VV);
        on = vis && msnap[(v >> CS) * 40 + 39 - (h >> CS)];
`ifdef GRIDLINES_EN
        grid = vis && ((h % (1 << CS)) == 0 || (v % (1 << CS)) == 0);
`else
        grid = 1'b0;
`endif
        rgb = on ? 12'hFFF : grid ? 12'h222 : 12'h000;
        hs = !(h >= HV + HF && h < HV + HF + HS);
        vs = !(v >= VV + VF && v < VV + VF + VS);
        return {rgb, hs, vs, fs};
    endfunction

    wire [14:0] pins = {bus.vga_r, bus.vga_g, bus.vga_b, bus.vga_hs, bus.vga_vs, bus.frame_start};
    wire [11:0] rgb = {bus.vga_r, bus.vga_g, bus.vga_b};

    always @(negedge clock) if (started) chk("pins", 32'(pins), 32'(model(cyc)));

    int first_fall = -1, hs_fall = -1, hs_per = -1, hs_low = -1;
    int vs_fall = -1, vs_per = -1, vs_low = -1;
    int fs_first = -1, fs_last = -1, fs_per = -1;
    logic prev_hs = 1'b1, prev_vs = 1'b1;
    logic meas = 1'b0;

    always @(negedge clock) if (meas) begin
        if (prev_hs && !bus.vga_hs) begin
            if (hs_fall >= 0) hs_per = cyc - hs_fall;
            if (first_fall < 0) first_fall = cyc;
            hs_fall = cyc;
        end
        if (!prev_hs && bus.vga_hs && hs_fall >= 0) hs_low = cyc - hs_fall;
        if (prev_vs && !bus.vga_vs) begin
            if (vs_fall >= 0) vs_per = cyc - vs_fall;
            vs_fall = cyc;
        end
        if (!prev_vs && bus.vga_vs && vs_fall >= 0) vs_low = cyc - vs_fall;
        if (bus.frame_start) begin
            if (fs_last >= 0) fs_per = cyc - fs_last;
            else fs_first = cyc;
            fs_last = cyc;
        end
        prev_hs = bus.vga_hs;
        prev_vs = bus.vga_vs;
    end

    task automatic at_pix(input int h, input int v, input logic [11:0] want, input string nm);
        int n = 0;
        while (((cyc - 2) % FT) != v * HT + h && n < FT + 10) begin
            @(negedge clock);
            n++;
        end
        if (n >= FT + 10) chk({nm, "_timeout"}, 32'(0), 32'(1));
        else chk(nm, 32'(rgb), 32'(want));
    endtask

    task automatic wait_fs();
        int n = 0;
        @(negedge clock);
        while (!bus.frame_start && n < FT + 10) begin
            @(negedge clock);
            n++;
        end
        if (n >= FT + 10) chk("frame_start_timeout", 32'(0), 32'(1));
    endtask

    logic [11:0] grid_c;
    logic [1199:0] r;

    initial begin
`ifdef GRIDLINES_EN
        grid_c = 12'h222;
`else
        grid_c = 12'h000;
`endif
        bus.framebuffer = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_pins", 32'(pins), 32'({12'h000, 1'b1, 1'b1, 1'b0}));
        reset = 1'b0;
        meas = 1'b1;
        bus.framebuffer[39] = 1'b1;
        wait_fs();
        at_pix(0, 0, 12'hFFF, "cell00_p00");
        bus.framebuffer[39] = 1'b0;
        bus.framebuffer[1160] = 1'b1;
        at_pix(2, 0, 12'h000, "cell00_right");
        at_pix(1, 1, 12'hFFF, "cell00_held_after_edit");
        at_pix(0, 2, 12'h000, "cell00_below");
        at_pix(78, 58, 12'h000, "cell1160_not_yet");
        wait_fs();
        at_pix(0, 0, 12'h000, "cell00_cleared");
        at_pix(0, 5, grid_c, "grid_0_5");
        at_pix(5, 5, 12'h000, "grid_5_5");
        at_pix(16, 5, grid_c, "grid_16_5");
        at_pix(78, 58, 12'hFFF, "cell1160_tl");
        at_pix(77, 59, 12'h000, "cell1160_left");
        at_pix(79, 59, 12'hFFF, "cell1160_br");
        at_pix(80, 59, 12'h000, "blank_right");
        chk("first_hs_low", 32'(first_fall), 32'(86));
        chk("hs_period", 32'(hs_per), 32'(102));
        chk("hs_low", 32'(hs_low), 32'(12));
        chk("vs_period", 32'(vs_per), 32'(6936));
        chk("vs_low", 32'(vs_low), 32'(204));
        chk("fs_first", 32'(fs_first), 32'(6121));
        chk("fs_period", 32'(fs_per), 32'(6936));
        meas = 1'b0;
        repeat (3) begin
            for (int i = 0; i < 1200; i++) r[i] = 1'($urandom_range(0, 1));
            bus.framebuffer = r;
            for (int k = 0; k < FT; k++) begin
                @(negedge clock);
                if ($urandom_range(0, 29) == 0) bus.framebuffer[$urandom_range(0, 1199)] ^= 1'b1;
            end
        end
        repeat ($urandom_range(10, 60)) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("midreset_pins", 32'(pins), 32'({12'h000, 1'b1, 1'b1, 1'b0}));
        reset = 1'b0;
        repeat (400) @(negedge clock);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
